// File: rtl/fetch_decode_stage_pkg.sv
// Shared definitions for the NanoQuarter front end and the execute stage.
//   - op encodings (instr[15:14]) and funct encodings (instr[2:0])
//   - fd_pipe_t: the fetch/decode -> execute pipeline register bundle
//   - FD_BUBBLE: the NOP bundle inserted on reset, redirect and load-use
package fetch_decode_stage_pkg;

  localparam int REG_W     = 16;
  localparam int REG_COUNT = 8;

  typedef enum logic [1:0] {
    OP_RTYPE = 2'b00,
    OP_IMM   = 2'b01,
    OP_MEM   = 2'b10,
    OP_CTRL  = 2'b11
  } op_e;

  // Memory-class functs
  localparam logic [2:0] FUNCT_LOAD  = 3'b000;
  localparam logic [2:0] FUNCT_STORE = 3'b001;
  // Control-class functs
  localparam logic [2:0] FUNCT_JMP   = 3'b000;
  localparam logic [2:0] FUNCT_JR    = 3'b001;
  localparam logic [2:0] FUNCT_BNE   = 3'b010;
  localparam logic [2:0] FUNCT_NOP   = 3'b111;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [REG_W-1:0]  reg1data;
    logic [REG_W-1:0]  reg2data;
    logic [7:0]        jtarget;
    logic [7:0]        idata;
    logic [5:0]        memaddr;
    logic [4:0]        boffset;
    logic [2:0]        funct;
    logic [1:0]        op;
    logic [1:0]        shamt;
    logic              bne;
    logic              jr;
    logic              jmp;
    logic              memread;
    logic              memwrite;
    logic [2:0]        wb_addr;
  } fd_pipe_t;

  // Bubble: everything zero except a control-class NOP encoding.
  localparam fd_pipe_t FD_BUBBLE = '{op: 2'b11, funct: 3'b111, default: '0};

endpackage

// File: rtl/fetch_decode_stage_regfile.sv
// nq_regfile: 8 x 16 register file.
//   clk, rst            : clock, synchronous active-high reset (clears all entries)
//   wb_en/wb_addr/wb_data : single write port, written on the rising edge
//   rd1_addr/rd1_data   : combinational read port 1 (with write bypass)
//   rd2_addr/rd2_data   : combinational read port 2 (with write bypass)
module nq_regfile
  import fetch_decode_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_en,
  input  logic [2:0]       wb_addr,
  input  logic [REG_W-1:0] wb_data,
  input  logic [2:0]       rd1_addr,
  output logic [REG_W-1:0] rd1_data,
  input  logic [2:0]       rd2_addr,
  output logic [REG_W-1:0] rd2_data
);

  logic [REG_W-1:0] regs [REG_COUNT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // A write landing this cycle is visible to a read in the same cycle.
  assign rd1_data = (wb_en && (wb_addr == rd1_addr)) ? wb_data : regs[rd1_addr];
  assign rd2_data = (wb_en && (wb_addr == rd2_addr)) ? wb_data : regs[rd2_addr];

endmodule

// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: PC, instruction fetch, decode, register read/bypass and
// the pipeline register feeding the execute stage.
//   clk, rst          : clock, synchronous active-high reset
//   imem_addr/imem_data : fetch address (current PC) and same-cycle instruction
//   stall             : hold PC and pipeline register
//   redirect/redirect_pc : next-PC override from execute, flushes the stage
//   wb_en/wb_addr/wb_data : register-file writeback from execute
//   valid_out .. wb_addr_out : registered decoded bundle
//
// Handshake: valid_out marks a real instruction in the pipeline register; stall
// is the consumer's "not ready" and freezes PC and the register (the bundle is
// held, not dropped). redirect overrides stall and replaces the bundle with a
// bubble.
module fetch_decode_stage
  import fetch_decode_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        wb_en,
  input  logic [2:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic        valid_out,
  output logic [31:0] PC_out,
  output logic [15:0] reg1data_out,
  output logic [15:0] reg2data_out,
  output logic [7:0]  jtarget_out,
  output logic [7:0]  idata_out,
  output logic [5:0]  memaddr_out,
  output logic [4:0]  boffset_out,
  output logic [2:0]  funct_out,
  output logic [1:0]  op_out,
  output logic [1:0]  shamt_out,
  output logic        bne_out,
  output logic        jr_out,
  output logic        jmp_out,
  output logic        memread_out,
  output logic        memwrite_out,
  output logic [2:0]  wb_addr_out
);

  logic [31:0] pc_q;
  fd_pipe_t    pipe_q;
  fd_pipe_t    dec;

  op_e         op;
  logic [2:0]  rs;
  logic [2:0]  rt;
  logic [2:0]  funct;
  logic [15:0] rd1;
  logic [15:0] rd2;
  logic        reads_rs;
  logic        reads_rt;
  logic        load_use;

  assign op    = op_e'(imem_data[15:14]);
  assign rs    = imem_data[13:11];
  assign rt    = imem_data[10:8];
  assign funct = imem_data[2:0];

  assign imem_addr = pc_q;

  nq_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .rd1_addr (rs),
    .rd1_data (rd1),
    .rd2_addr (rt),
    .rd2_data (rd2)
  );

  // Which operands the current instruction really consumes; only those can
  // create a load-use dependency.
  assign reads_rs = (op != OP_CTRL) || (funct == FUNCT_JR) || (funct == FUNCT_BNE);
  assign reads_rt = (op == OP_RTYPE)
                 || ((op == OP_MEM)  && (funct == FUNCT_STORE))
                 || ((op == OP_CTRL) && (funct == FUNCT_BNE));

  assign load_use = pipe_q.valid && pipe_q.memread &&
                    ((reads_rs && (rs == pipe_q.wb_addr)) ||
                     (reads_rt && (rt == pipe_q.wb_addr)));

  always_comb begin
    dec          = FD_BUBBLE;
    dec.valid    = 1'b1;
    dec.pc       = pc_q;
    dec.reg1data = rd1;
    dec.reg2data = rd2;
    dec.jtarget  = imem_data[7:0];
    dec.idata    = imem_data[7:0];
    dec.memaddr  = imem_data[5:0];
    dec.boffset  = imem_data[4:0];
    dec.funct    = funct;
    dec.op       = imem_data[15:14];
    dec.shamt    = imem_data[4:3];
    dec.wb_addr  = rs;
    dec.memread  = (op == OP_MEM)  && (funct == FUNCT_LOAD);
    dec.memwrite = (op == OP_MEM)  && (funct == FUNCT_STORE);
    // jr is a register-indirect jump, so it also raises jmp.
    dec.jmp      = (op == OP_CTRL) && ((funct == FUNCT_JMP) || (funct == FUNCT_JR));
    dec.jr       = (op == OP_CTRL) && (funct == FUNCT_JR);
    dec.bne      = (op == OP_CTRL) && (funct == FUNCT_BNE) && (rd1 != rd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      pipe_q    <= FD_BUBBLE;
      pipe_q.pc <= RESET_PC;
    end else if (redirect) begin
      pc_q   <= redirect_pc;
      pipe_q <= FD_BUBBLE;
    end else if (stall) begin
      pc_q   <= pc_q;
      pipe_q <= pipe_q;
    end else if (load_use) begin
      // Re-fetch the same instruction next cycle once the load has moved on.
      pc_q   <= pc_q;
      pipe_q <= FD_BUBBLE;
    end else begin
      pc_q   <= pc_q + PC_STEP;
      pipe_q <= dec;
    end
  end

  assign valid_out    = pipe_q.valid;
  assign PC_out       = pipe_q.pc;
  assign reg1data_out = pipe_q.reg1data;
  assign reg2data_out = pipe_q.reg2data;
  assign jtarget_out  = pipe_q.jtarget;
  assign idata_out    = pipe_q.idata;
  assign memaddr_out  = pipe_q.memaddr;
  assign boffset_out  = pipe_q.boffset;
  assign funct_out    = pipe_q.funct;
  assign op_out       = pipe_q.op;
  assign shamt_out    = pipe_q.shamt;
  assign bne_out      = pipe_q.bne;
  assign jr_out       = pipe_q.jr;
  assign jmp_out      = pipe_q.jmp;
  assign memread_out  = pipe_q.memread;
  assign memwrite_out = pipe_q.memwrite;
  assign wb_addr_out  = pipe_q.wb_addr;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: directed vector table followed by randomized
// traffic checked against an instruction-level reference model.
module tb_fetch_decode_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        valid_out;
  logic [31:0] PC_out;
  logic [15:0] reg1data_out, reg2data_out;
  logic [7:0]  jtarget_out, idata_out;
  logic [5:0]  memaddr_out;
  logic [4:0]  boffset_out;
  logic [2:0]  funct_out;
  logic [1:0]  op_out, shamt_out;
  logic        bne_out, jr_out, jmp_out, memread_out, memwrite_out;
  logic [2:0]  wb_addr_out;

  fetch_decode_stage #(.RESET_PC(RESET_PC), .PC_STEP(32'd2)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .valid_out(valid_out), .PC_out(PC_out),
    .reg1data_out(reg1data_out), .reg2data_out(reg2data_out),
    .jtarget_out(jtarget_out), .idata_out(idata_out), .memaddr_out(memaddr_out),
    .boffset_out(boffset_out), .funct_out(funct_out), .op_out(op_out),
    .shamt_out(shamt_out), .bne_out(bne_out), .jr_out(jr_out), .jmp_out(jmp_out),
    .memread_out(memread_out), .memwrite_out(memwrite_out), .wb_addr_out(wb_addr_out)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];   // expected fetch addresses

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // flags = {bne, jr, jmp, memread, memwrite}
  task automatic check_outputs(input string tag, input logic ev, input logic [31:0] epc,
                               input logic [15:0] ei, input logic [15:0] er1,
                               input logic [15:0] er2, input logic [4:0] ef);
    logic [15:0] i;
    logic [15:0] r1, r2;
    logic [4:0]  f;
    logic [2:0]  wa;
    if (ev) begin
      i = ei; r1 = er1; r2 = er2; f = ef; wa = ei[13:11];
    end else begin
      i = 16'hC007; r1 = '0; r2 = '0; f = '0; wa = '0;
      i[7:3] = 5'b0;
    end
    chk({tag, ".valid_out"}, valid_out, ev);
    chk({tag, ".PC_out"}, PC_out, epc);
    chk({tag, ".op_out"}, op_out, i[15:14]);
    chk({tag, ".funct_out"}, funct_out, i[2:0]);
    chk({tag, ".wb_addr_out"}, wb_addr_out, wa);
    chk({tag, ".reg1data_out"}, reg1data_out, r1);
    chk({tag, ".reg2data_out"}, reg2data_out, r2);
    chk({tag, ".flags"}, {bne_out, jr_out, jmp_out, memread_out, memwrite_out}, f);
    if (ev) begin
      chk({tag, ".jtarget_out"}, jtarget_out, i[7:0]);
      chk({tag, ".idata_out"}, idata_out, i[7:0]);
      chk({tag, ".memaddr_out"}, memaddr_out, i[5:0]);
      chk({tag, ".boffset_out"}, boffset_out, i[4:0]);
      chk({tag, ".shamt_out"}, shamt_out, i[4:3]);
    end else begin
      chk({tag, ".bubble_fields"}, {jtarget_out, idata_out, memaddr_out, boffset_out, shamt_out}, '0);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic [15:0] ins, input logic st,
                       input logic rd, input logic [31:0] rpc, input logic we,
                       input logic [2:0] wa, input logic [15:0] wd);
    @(negedge clk);
    rst = r; imem_data = ins; stall = st; redirect = rd; redirect_pc = rpc;
    wb_en = we; wb_addr = wa; wb_data = wd;
  endtask

  function automatic logic [15:0] mk(input logic [1:0] op, input logic [2:0] rs,
                                     input logic [2:0] rt, input logic [7:0] lo);
    return {op, rs, rt, lo};
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [15:0] instr;
    logic        st, rd;
    logic [31:0] rpc;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [31:0] ia;      // expected imem_addr before the edge
    logic        ev;
    logic [31:0] epc;
    logic [15:0] ei;      // instruction expected in the pipeline register
    logic [15:0] er1, er2;
    logic [4:0]  ef;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t v(input logic [15:0] ins, input logic st, input logic rd,
                             input logic [31:0] rpc, input logic we, input logic [2:0] wa,
                             input logic [15:0] wd, input logic [31:0] ia, input logic ev,
                             input logic [31:0] epc, input logic [15:0] ei,
                             input logic [15:0] er1, input logic [15:0] er2,
                             input logic [4:0] ef);
    vec_t x;
    x.instr = ins; x.st = st; x.rd = rd; x.rpc = rpc; x.we = we; x.wa = wa; x.wd = wd;
    x.ia = ia; x.ev = ev; x.epc = epc; x.ei = ei; x.er1 = er1; x.er2 = er2; x.ef = ef;
    return x;
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  logic [15:0] m_rf [8];
  logic        e_valid;
  logic [31:0] e_pc;
  logic [15:0] e_instr, e_r1, e_r2;
  logic [4:0]  e_flags;

  task automatic model_step(input logic r, input logic [15:0] ins, input logic st,
                            input logic rd, input logic [31:0] rpc, input logic we,
                            input logic [2:0] wa, input logic [15:0] wd);
    logic [1:0]  op;
    logic [2:0]  rs, rt, fn;
    logic [15:0] a, b;
    logic        uses_rs, uses_rt, prev_load;
    if (r) begin
      m_pc = RESET_PC; e_valid = 1'b0; e_pc = RESET_PC;
      for (int k = 0; k < 8; k++) m_rf[k] = '0;
      return;
    end
    op = ins[15:14]; rs = ins[13:11]; rt = ins[10:8]; fn = ins[2:0];
    a = (we && wa == rs) ? wd : m_rf[rs];
    b = (we && wa == rt) ? wd : m_rf[rt];
    if (we) m_rf[wa] = wd;
    uses_rs   = (op != 2'd3) || fn == 3'd1 || fn == 3'd2;
    uses_rt   = (op == 2'd0) || (op == 2'd2 && fn == 3'd1) || (op == 2'd3 && fn == 3'd2);
    prev_load = e_valid && e_instr[15:14] == 2'd2 && e_instr[2:0] == 3'd0;
    if (rd) begin
      m_pc = rpc; e_valid = 1'b0; e_pc = '0;
    end else if (st) begin
      // everything holds
    end else if (prev_load && ((uses_rs && rs == e_instr[13:11]) ||
                               (uses_rt && rt == e_instr[13:11]))) begin
      e_valid = 1'b0; e_pc = '0;
    end else begin
      e_valid = 1'b1; e_pc = m_pc; e_instr = ins; e_r1 = a; e_r2 = b;
      e_flags = {op == 2'd3 && fn == 3'd2 && a != b,
                 op == 2'd3 && fn == 3'd1,
                 op == 2'd3 && (fn == 3'd0 || fn == 3'd1),
                 op == 2'd2 && fn == 3'd0,
                 op == 2'd2 && fn == 3'd1};
      m_pc = m_pc + 32'd2;
    end
  endtask

  // ---------------- test ----------------
  initial begin
    rst = 1'b1; imem_data = '0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;

    vecs[0]  = v(mk(0,1,2,8'h00),0,0,0,0,0,16'h0,    32'h00,1,32'h00,mk(0,1,2,8'h00),16'h0,16'h0,5'b00000);
    vecs[1]  = v(mk(0,3,4,8'h00),0,0,0,1,3,16'hBEEF, 32'h02,1,32'h02,mk(0,3,4,8'h00),16'hBEEF,16'h0,5'b00000);
    vecs[2]  = v(mk(0,3,0,8'h18),0,0,0,0,0,16'h0,    32'h04,1,32'h04,mk(0,3,0,8'h18),16'hBEEF,16'h0,5'b00000);
    vecs[3]  = v(mk(0,5,0,8'h00),0,0,0,1,1,16'h0005, 32'h06,1,32'h06,mk(0,5,0,8'h00),16'h0,16'h0,5'b00000);
    vecs[4]  = v(mk(0,1,2,8'h00),0,0,0,1,2,16'h0005, 32'h08,1,32'h08,mk(0,1,2,8'h00),16'h5,16'h5,5'b00000);
    vecs[5]  = v(mk(3,1,2,8'h12),0,0,0,0,0,16'h0,    32'h0A,1,32'h0A,mk(3,1,2,8'h12),16'h5,16'h5,5'b00000);
    vecs[6]  = v(mk(3,1,2,8'h02),0,0,0,1,2,16'h0006, 32'h0C,1,32'h0C,mk(3,1,2,8'h02),16'h5,16'h6,5'b10000);
    vecs[7]  = v(mk(3,1,0,8'h01),0,0,0,0,0,16'h0,    32'h0E,1,32'h0E,mk(3,1,0,8'h01),16'h5,16'h0,5'b01100);
    vecs[8]  = v(mk(2,2,0,8'h00),0,0,0,0,0,16'h0,    32'h10,1,32'h10,mk(2,2,0,8'h00),16'h6,16'h0,5'b00010);
    vecs[9]  = v(mk(0,2,3,8'h00),0,0,0,0,0,16'h0,    32'h12,0,32'h00,16'h0,16'h0,16'h0,5'b00000);
    vecs[10] = v(mk(0,2,3,8'h00),0,0,0,0,0,16'h0,    32'h12,1,32'h12,mk(0,2,3,8'h00),16'h6,16'hBEEF,5'b00000);
    vecs[11] = v(mk(0,0,0,8'h00),1,1,32'h40,0,0,16'h0,32'h14,0,32'h00,16'h0,16'h0,16'h0,5'b00000);
    vecs[12] = v(mk(1,4,0,8'hA5),0,0,0,0,0,16'h0,    32'h40,1,32'h40,mk(1,4,0,8'hA5),16'h0,16'h0,5'b00000);
    vecs[13] = v(mk(0,7,7,8'hFF),1,0,0,1,4,16'h1234, 32'h42,1,32'h40,mk(1,4,0,8'hA5),16'h0,16'h0,5'b00000);
    vecs[14] = v(mk(2,0,0,8'h00),1,0,0,0,0,16'h0,    32'h42,1,32'h40,mk(1,4,0,8'hA5),16'h0,16'h0,5'b00000);
    vecs[15] = v(mk(3,0,0,8'h01),1,0,0,0,0,16'h0,    32'h42,1,32'h40,mk(1,4,0,8'hA5),16'h0,16'h0,5'b00000);
    vecs[16] = v(mk(0,4,0,8'h00),0,0,0,0,0,16'h0,    32'h42,1,32'h42,mk(0,4,0,8'h00),16'h1234,16'h0,5'b00000);
    vecs[17] = v(mk(2,3,1,8'h01),0,0,0,0,0,16'h0,    32'h44,1,32'h44,mk(2,3,1,8'h01),16'hBEEF,16'h5,5'b00001);
    vecs[18] = v(mk(3,0,0,8'h00),0,0,0,0,0,16'h0,    32'h46,1,32'h46,mk(3,0,0,8'h00),16'h0,16'h0,5'b00100);
    vecs[19] = v(mk(2,5,0,8'h00),0,0,0,0,0,16'h0,    32'h48,1,32'h48,mk(2,5,0,8'h00),16'h0,16'h0,5'b00010);
    vecs[20] = v(mk(2,1,5,8'h01),0,0,0,0,0,16'h0,    32'h4A,0,32'h00,16'h0,16'h0,16'h0,5'b00000);
    vecs[21] = v(mk(2,1,5,8'h01),0,0,0,0,0,16'h0,    32'h4A,1,32'h4A,mk(2,1,5,8'h01),16'h5,16'h0,5'b00001);
    vecs[22] = v(mk(2,6,0,8'h00),0,0,0,0,0,16'h0,    32'h4C,1,32'h4C,mk(2,6,0,8'h00),16'h0,16'h0,5'b00010);
    vecs[23] = v(mk(3,6,6,8'h00),0,0,0,0,0,16'h0,    32'h4E,1,32'h4E,mk(3,6,6,8'h00),16'h0,16'h0,5'b00100);
    vecs[24] = v(mk(2,7,0,8'h00),0,0,0,0,0,16'h0,    32'h50,1,32'h50,mk(2,7,0,8'h00),16'h0,16'h0,5'b00010);
    vecs[25] = v(mk(1,0,7,8'h3C),0,0,0,0,0,16'h0,    32'h52,1,32'h52,mk(1,0,7,8'h3C),16'h0,16'h0,5'b00000);

    // Reset state
    drive(1, '0, 0, 0, '0, 0, '0, '0);
    @(posedge clk); #1;
    drive(1, '0, 0, 0, '0, 0, '0, '0);
    @(posedge clk); #1;
    chk("reset.imem_addr", imem_addr, RESET_PC);
    check_outputs("reset", 1'b0, RESET_PC, 16'h0, 16'h0, 16'h0, 5'b0);

    // Directed table
    for (int n = 0; n < 26; n++) begin
      drive(0, vecs[n].instr, vecs[n].st, vecs[n].rd, vecs[n].rpc,
            vecs[n].we, vecs[n].wa, vecs[n].wd);
      #1;
      chk($sformatf("vec%0d.imem_addr", n), imem_addr, vecs[n].ia);
      @(posedge clk); #1;
      check_outputs($sformatf("vec%0d", n), vecs[n].ev, vecs[n].epc, vecs[n].ei,
                    vecs[n].er1, vecs[n].er2, vecs[n].ef);
    end

    // Mid-operation reset, then randomized traffic against the model
    drive(1, '0, 0, 0, '0, 0, '0, '0);
    model_step(1, '0, 0, 0, '0, 0, '0, '0);
    @(posedge clk); #1;
    check_outputs("midreset", e_valid, e_pc, e_instr, e_r1, e_r2, e_flags);

    for (int n = 0; n < 600; n++) begin
      logic        r, st, rd, we;
      logic [15:0] ins, wd;
      logic [31:0] rpc;
      logic [2:0]  wa;
      ins = 16'($urandom);
      ins[13:11] = 3'($urandom_range(0, 3));
      ins[10:8]  = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        ins[15:14] = 2'b10;
        ins[2:0]   = 3'b000;
      end
      r   = ($urandom_range(0, 99) == 0);
      st  = ($urandom_range(0, 7) == 0);
      rd  = ($urandom_range(0, 15) == 0);
      rpc = 32'($urandom_range(0, 255)) * 32'd2;
      we  = $urandom_range(0, 1) == 1;
      wa  = 3'($urandom_range(0, 3));
      wd  = 16'($urandom);
      drive(r, ins, st, rd, rpc, we, wa, wd);
      exp_q.push_back(m_pc);
      #1;
      chk($sformatf("rnd%0d.imem_addr", n), imem_addr, exp_q.pop_front());
      model_step(r, ins, st, rd, rpc, we, wa, wd);
      @(posedge clk); #1;
      check_outputs($sformatf("rnd%0d", n), e_valid, e_pc, e_instr, e_r1, e_r2, e_flags);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
